// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pipelined bitwise reduction unit.
package reduce_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } reduce_op_e;

    // Combine two bits with the selected operator; the reserved code behaves as AND.
    function automatic logic op_apply(input reduce_op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Value that leaves the operator's result unchanged, used to pad the tree.
    function automatic logic op_identity(input reduce_op_e op);
        logic r;
        case (op)
            OP_OR:   r = 1'b0;
            OP_XOR:  r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reduce_pipe_if.sv
// Streaming bundle: word source side (in_*) and result consumer side (out_*).
interface reduce_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    import reduce_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_last;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid;
    logic              out_ready;
    logic              out_result;
    logic [CNT_W-1:0]  out_beats;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_result, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_result, out_beats, out_ovf
    );
endinterface

// File: rtl/reduce_level.sv
// One registered level of the reduction tree: halves the width, forwards sideband.
module reduce_level
    import reduce_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic                last_i,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic [IN_W-1:0]     data_i,
    output logic                valid_o,
    output logic                last_o,
    output logic [MODE_W-1:0]   mode_o,
    output logic [IN_W/2-1:0]   data_o
);
    localparam int OUT_W = IN_W / 2;

    logic [OUT_W-1:0]  half_d;
    logic [OUT_W-1:0]  data_q;
    logic              valid_q;
    logic              last_q;
    logic [MODE_W-1:0] mode_q;

    // Pairwise combine adjacent bits with the beat's operator.
    always_comb begin
        half_d = {OUT_W{1'b0}};
        for (int k = 0; k < OUT_W; k++) begin
            half_d[k] = op_apply(reduce_op_e'(mode_i[1:0]), data_i[2*k], data_i[2*k+1]);
        end
    end

    // Level bank: loads when the pipe advances, holds during a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= {OUT_W{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            mode_q  <= {MODE_W{1'b0}};
        end else if (en_i) begin
            data_q  <= half_d;
            valid_q <= valid_i;
            last_q  <= last_i;
            mode_q  <= mode_i;
        end else begin
            data_q  <= data_q;
            valid_q <= valid_q;
            last_q  <= last_q;
            mode_q  <= mode_q;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign mode_o  = mode_q;

endmodule

// File: rtl/reduce_pipe.sv
// Pipelined multi-mode reducer: per-beat tree, per-packet fold, valid/ready both sides.
module reduce_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    reduce_pipe_if.slave  bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;
    // Tree nodes laid out level after level: leaves first, root in the top bit.
    localparam int TREE_W = 2 * LEAVES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              adv_s;
    logic              in_first_q;
    logic [MODE_W-1:0] pkt_mode_q;
    logic [MODE_W-1:0] eff_mode_s;
    logic              pad_s;
    logic [LEAVES-1:0] leaves_s;
    logic [TREE_W-1:0] tree_s;
    logic              lvl_valid_s [0:LEVELS];
    logic              lvl_last_s  [0:LEVELS];
    logic [MODE_W-1:0] lvl_mode_s  [0:LEVELS];

    logic              first_q, first_d;
    logic              acc_q, acc_d, acc_new_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_new_s;
    logic              ovf_q, ovf_d, ovf_new_s;
    logic              out_valid_q, out_valid_d;
    logic              out_result_q, out_result_d;
    logic [CNT_W-1:0]  out_beats_q, out_beats_d;
    logic              out_ovf_q, out_ovf_d;

    // Whole pipe advances unless a result is waiting on a busy consumer.
    assign adv_s       = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = adv_s;

    // Later beats of a packet reuse the mode captured on its first beat.
    always_comb begin
        if (in_first_q) begin
            eff_mode_s = bus.in_mode;
        end else begin
            eff_mode_s = pkt_mode_q;
        end
    end

    // Track packet boundaries on the input side and capture the packet mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_first_q <= 1'b1;
            pkt_mode_q <= {MODE_W{1'b0}};
        end else if (bus.in_valid && adv_s) begin
            in_first_q <= bus.in_last;
            pkt_mode_q <= eff_mode_s;
        end else begin
            in_first_q <= in_first_q;
            pkt_mode_q <= pkt_mode_q;
        end
    end

    assign pad_s = op_identity(reduce_op_e'(eff_mode_s[1:0]));

    // Pad unused leaves with the operator identity so they never change the result.
    always_comb begin
        leaves_s              = {LEAVES{pad_s}};
        leaves_s[WIDTH-1:0]   = bus.in_data;
    end

    assign tree_s[LEAVES-1:0] = leaves_s;
    assign lvl_valid_s[0]     = bus.in_valid;
    assign lvl_last_s[0]      = bus.in_last;
    assign lvl_mode_s[0]      = eff_mode_s;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_W    = LEAVES >> l;
        localparam int IN_OFF  = 2 * LEAVES - 2 * (LEAVES >> l);
        localparam int OUT_OFF = 2 * LEAVES - 2 * (LEAVES >> (l + 1));
        reduce_level #(.IN_W(IN_W)) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (adv_s),
            .valid_i (lvl_valid_s[l]),
            .last_i  (lvl_last_s[l]),
            .mode_i  (lvl_mode_s[l]),
            .data_i  (tree_s[IN_OFF +: IN_W]),
            .valid_o (lvl_valid_s[l+1]),
            .last_o  (lvl_last_s[l+1]),
            .mode_o  (lvl_mode_s[l+1]),
            .data_o  (tree_s[OUT_OFF +: IN_W/2])
        );
    end

    // Fold the tree root into the running packet value and publish on the last beat.
    always_comb begin
        first_d      = first_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_beats_d  = out_beats_q;
        out_ovf_d    = out_ovf_q;
        if (first_q) begin
            acc_new_s = tree_s[TREE_W-1];
            cnt_new_s = CNT_ONE;
            ovf_new_s = 1'b0;
        end else begin
            acc_new_s = op_apply(reduce_op_e'(lvl_mode_s[LEVELS][1:0]), acc_q, tree_s[TREE_W-1]);
            if (cnt_q == CNT_MAX) begin
                cnt_new_s = cnt_q;
                ovf_new_s = 1'b1;
            end else begin
                cnt_new_s = cnt_q + CNT_ONE;
                ovf_new_s = ovf_q;
            end
        end
        if (adv_s) begin
            if (lvl_valid_s[LEVELS]) begin
                if (lvl_last_s[LEVELS]) begin
                    out_valid_d  = 1'b1;
                    out_result_d = acc_new_s ^ lvl_mode_s[LEVELS][2];
                    out_beats_d  = cnt_new_s;
                    out_ovf_d    = ovf_new_s;
                    first_d      = 1'b1;
                    acc_d        = 1'b0;
                    cnt_d        = {CNT_W{1'b0}};
                    ovf_d        = 1'b0;
                end else begin
                    out_valid_d  = 1'b0;
                    first_d      = 1'b0;
                    acc_d        = acc_new_s;
                    cnt_d        = cnt_new_s;
                    ovf_d        = ovf_new_s;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q      <= 1'b1;
            acc_q        <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_beats_q  <= {CNT_W{1'b0}};
            out_ovf_q    <= 1'b0;
        end else begin
            first_q      <= first_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_beats_q  <= out_beats_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_beats  = out_beats_q;
    assign bus.out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_reduce_pipe.sv
// Randomized bench for reduce_pipe: two instances (16-bit/8-bit count, 5-bit/2-bit count)
// checked against a packet-level reference model and result scoreboards.
module tb_reduce_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reduce_pipe_if #(.WIDTH(16), .CNT_W(8)) bus_a ();
    reduce_pipe_if #(.WIDTH(5),  .CNT_W(2)) bus_b ();

    reduce_pipe #(.WIDTH(16), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    reduce_pipe #(.WIDTH(5),  .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct packed {
        logic       res;
        logic [7:0] beats;
        logic       ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Packet-level model state per instance (0 = A, 1 = B).
    logic       m_first [2];
    logic [2:0] m_mode  [2];
    logic       m_acc   [2];
    int         m_cnt   [2];
    int         rdy_mode_a = 1;  // 0 low, 1 high, 2 random
    int         rdy_mode_b = 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int width_of(input int id);
        return (id == 0) ? 16 : 5;
    endfunction

    function automatic int max_of(input int id);
        return (id == 0) ? 255 : 3;
    endfunction

    // Reduction of one beat from the operator's definition.
    function automatic logic beat_red(input logic [1:0] op, input logic [15:0] d, input int w);
        logic [15:0] mask;
        logic [15:0] v;
        mask = 16'hFFFF >> (16 - w);
        v    = d & mask;
        case (op)
            2'b01:   return v != 16'h0000;
            2'b10:   return ^v;
            default: return v == mask;
        endcase
    endfunction

    task automatic model_beat(input int id, input logic [15:0] d, input logic l, input logic [2:0] m);
        logic b;
        exp_t e;
        if (m_first[id]) m_mode[id] = m;
        b = beat_red(m_mode[id][1:0], d, width_of(id));
        if (m_first[id]) begin
            m_acc[id] = b;
            m_cnt[id] = 1;
        end else begin
            case (m_mode[id][1:0])
                2'b01:   m_acc[id] = m_acc[id] | b;
                2'b10:   m_acc[id] = m_acc[id] ^ b;
                default: m_acc[id] = m_acc[id] & b;
            endcase
            m_cnt[id] = m_cnt[id] + 1;
        end
        m_first[id] = l;
        if (l) begin
            e.res   = m_acc[id] ^ m_mode[id][2];
            e.beats = 8'((m_cnt[id] > max_of(id)) ? max_of(id) : m_cnt[id]);
            e.ovf   = m_cnt[id] > max_of(id);
            if (id == 0) q_a.push_back(e);
            else         q_b.push_back(e);
        end
    endtask

    // Consumer ready generators.
    initial begin
        bus_a.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode_a)
                0:       bus_a.out_ready = 1'b0;
                1:       bus_a.out_ready = 1'b1;
                default: bus_a.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        bus_b.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode_b)
                0:       bus_b.out_ready = 1'b0;
                1:       bus_b.out_ready = 1'b1;
                default: bus_b.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboards: compare each accepted result with the model's next packet.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
            check_val("a_pending", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check_val("a_result", 32'(bus_a.out_result), 32'(e.res));
                check_val("a_beats",  32'(bus_a.out_beats),  32'(e.beats));
                check_val("a_ovf",    32'(bus_a.out_ovf),    32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
            check_val("b_pending", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check_val("b_result", 32'(bus_b.out_result), 32'(e.res));
                check_val("b_beats",  32'(bus_b.out_beats),  32'(e.beats));
                check_val("b_ovf",    32'(bus_b.out_ovf),    32'(e.ovf));
            end
        end
    end

    task automatic drive(input int id, input logic [15:0] d, input logic l, input logic [2:0] m);
        int   waits;
        logic took;
        waits = 0;
        took  = 1'b0;
        if (id == 0) begin
            bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_last = l; bus_a.in_mode = m;
        end else begin
            bus_b.in_valid = 1'b1; bus_b.in_data = d[4:0]; bus_b.in_last = l; bus_b.in_mode = m;
        end
        while (!took && waits < 200) begin
            @(negedge clk);
            took = (id == 0) ? bus_a.in_ready : bus_b.in_ready;
            @(posedge clk); #1;
            waits++;
        end
        if (!took) check_val("accept_timeout", 32'(took), 32'd1);
        else       model_beat(id, d, l, m);
        if (id == 0) bus_a.in_valid = 1'b0;
        else         bus_b.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) check_val("drain_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
        idle(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_val({tag, "_a_valid"},  32'(bus_a.out_valid),  32'd0);
        check_val({tag, "_a_result"}, 32'(bus_a.out_result), 32'd0);
        check_val({tag, "_a_beats"},  32'(bus_a.out_beats),  32'd0);
        check_val({tag, "_a_ovf"},    32'(bus_a.out_ovf),    32'd0);
        check_val({tag, "_a_ready"},  32'(bus_a.in_ready),   32'd1);
        check_val({tag, "_b_valid"},  32'(bus_b.out_valid),  32'd0);
        check_val({tag, "_b_ready"},  32'(bus_b.in_ready),   32'd1);
        @(posedge clk); #1;
    endtask

    task automatic measure_latency(input int id, input string tag, input int exp_lat);
        int n;
        n = 0;
        while (((id == 0) ? !bus_a.out_valid : !bus_b.out_valid) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, 32'(n + 1), 32'(exp_lat));
    endtask

    function automatic logic [15:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_data = 16'h0; bus_a.in_last = 1'b0; bus_a.in_mode = 3'b000;
        bus_b.in_valid = 1'b0; bus_b.in_data = 5'h0;  bus_b.in_last = 1'b0; bus_b.in_mode = 3'b000;
        for (int i = 0; i < 2; i++) begin
            m_first[i] = 1'b1; m_mode[i] = 3'b000; m_acc[i] = 1'b0; m_cnt[i] = 0;
        end
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        check_reset_outputs("rst");

        // Single-beat AND, latency on the 16-bit instance, then a failing word.
        drive(0, 16'hFFFF, 1'b1, 3'b000);
        measure_latency(0, "a_latency", 5);
        drive(0, 16'hFFFE, 1'b1, 3'b000);
        drain();

        // Multi-beat XOR with invert; later beats carry a different mode that must be ignored.
        drive(0, 16'h0001, 1'b0, 3'b110);
        drive(0, 16'h0003, 1'b0, 3'b001);
        drive(0, 16'h0000, 1'b1, 3'b000);
        drain();

        // Non-power-of-two width: padding identity and shorter latency.
        drive(1, 16'h0000, 1'b1, 3'b001);
        measure_latency(1, "b_latency", 4);
        drive(1, 16'h001F, 1'b1, 3'b000);
        drive(1, 16'h001F, 1'b1, 3'b011);
        drive(1, 16'h0010, 1'b1, 3'b010);
        drain();

        // Backpressure: four packets queue up behind a stalled consumer.
        rdy_mode_a = 0;
        idle(1);
        for (int i = 0; i < 4; i++) drive(0, rand_data(), 1'b1, 3'($urandom_range(0, 7)));
        idle(6);
        @(negedge clk);
        check_val("bp_in_ready",  32'(bus_a.in_ready),  32'd0);
        check_val("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
        @(posedge clk); #1;
        rdy_mode_a = 1;
        drain();

        // Saturating beat count on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) drive(1, 16'(i * 3), (i == 4), 3'b001);
        drive(1, 16'h0001, 1'b1, 3'b001);
        drain();

        // Reset in the middle of a packet discards it entirely.
        drive(0, 16'hFFFF, 1'b0, 3'b000);
        drive(0, 16'hFFFF, 1'b0, 3'b000);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        m_first[0] = 1'b1;
        m_first[1] = 1'b1;
        check_reset_outputs("midrst");
        drive(0, 16'h1234, 1'b1, 3'b001);
        drain();

        // Random packets, modes, bubbles and consumer stalls on both instances.
        rdy_mode_a = 2;
        rdy_mode_b = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                drive(0, rand_data(), (b == len - 1), 3'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                drive(1, rand_data(), (b == len - 1), 3'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rdy_mode_a = 1;
        rdy_mode_b = 1;
        drain();
        check_val("final_q_a", 32'(q_a.size()), 32'd0);
        check_val("final_q_b", 32'(q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
